// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg : opcodes, widths and FSM state encoding for the SPI initiator.
// Rev 1.0
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    TURN = 3'd2,
    READ = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_clk_div : half-period counter producing sclk and one-clk rise/fall strobes.
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             at_last;

  // Strobes mark the clk edge on which sclk will change.
  assign at_last = en && (cnt_q == LAST);
  assign rise    = at_last && !sclk_q;
  assign fall    = at_last && sclk_q;
  assign sclk    = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en || clr) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_master : mode-0 SPI initiator; 10-bit command out, optional 8-bit read back.
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int TURNAROUND = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              ss_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_W  = ($clog2(TURNAROUND) > 4) ? $clog2(TURNAROUND) : 4;
  localparam int HOLD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e              state_q, state_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CMD_W-1:0]    tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                is_rd_q, is_rd_d;
  logic                ss_n_q, ss_n_d;
  logic                mosi_q, mosi_d;
  logic                rd_valid_q, rd_valid_d;
  logic                div_en, div_clr, sclk_rise, sclk_fall;

  assign div_en  = (state_q == CMD) || (state_q == TURN) || (state_q == READ);
  assign div_clr = (state_d != state_q);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .clr   (div_clr),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    hold_d     = hold_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    is_rd_d    = is_rd_q;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
        if (cmd_valid) begin
          tx_d      = cmd_data;
          is_rd_d   = (cmd_data[CMD_W-1 -: 2] == OP_RD_DATA);
          ss_n_d    = 1'b0;
          mosi_d    = cmd_data[CMD_W-1];
          bit_cnt_d = '0;
          state_d   = CMD;
        end
      end
      CMD: begin
        // mosi advances on the falling edge so it is stable across the rise.
        if (sclk_fall) begin
          if (bit_cnt_q == BIT_W'(CMD_W - 1)) begin
            mosi_d    = 1'b0;
            bit_cnt_d = '0;
            if (is_rd_q) begin
              state_d = (TURNAROUND == 0) ? READ : TURN;
            end else begin
              ss_n_d  = 1'b1;
              hold_d  = '0;
              state_d = DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            mosi_d    = tx_q[CMD_W-2];
            tx_d      = {tx_q[CMD_W-2:0], 1'b0};
          end
        end
      end
      TURN: begin
        if (sclk_fall) begin
          if (bit_cnt_q == BIT_W'(TURNAROUND - 1)) begin
            bit_cnt_d = '0;
            state_d   = READ;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      READ: begin
        if (sclk_rise) rx_d = {rx_q[DATA_W-2:0], miso};
        if (sclk_fall) begin
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            ss_n_d     = 1'b1;
            rd_data_d  = rx_q;
            rd_valid_d = 1'b1;
            hold_d     = '0;
            state_d    = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      DONE: begin
        if (hold_q == HOLD_W'(CLK_DIV - 1)) state_d = IDLE;
        else                                 hold_d  = hold_q + HOLD_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      hold_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      is_rd_q    <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      is_rd_q    <= is_rd_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign ss_n      = ss_n_q;
  assign mosi      = mosi_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_master : two configurations (CLK_DIV=2/TA=2 and CLK_DIV=1/TA=0) vs frame model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       sel = 1'b0;
  logic [9:0] cmd_data = '0;
  logic       miso_a = 1'b0, miso_b = 1'b0;
  logic [7:0] slave_byte = '0;
  logic [7:0] model_rd [2];
  int         total = 0, bad = 0;

  logic       cmd_valid_a, cmd_valid_b;
  logic       cmd_ready_a, cmd_ready_b, rd_valid_a, rd_valid_b, busy_a, busy_b;
  logic       ss_n_a, ss_n_b, sclk_a, sclk_b, mosi_a, mosi_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       m_ready, m_rdv, m_busy, m_ss_n, m_sclk, m_mosi;
  logic [7:0] m_rd_data;

  assign cmd_valid_a = cmd_valid && !sel;
  assign cmd_valid_b = cmd_valid && sel;
  assign m_ready     = sel ? cmd_ready_b : cmd_ready_a;
  assign m_rdv       = sel ? rd_valid_b  : rd_valid_a;
  assign m_busy      = sel ? busy_b      : busy_a;
  assign m_ss_n      = sel ? ss_n_b      : ss_n_a;
  assign m_sclk      = sel ? sclk_b      : sclk_a;
  assign m_mosi      = sel ? mosi_b      : mosi_a;
  assign m_rd_data   = sel ? rd_data_b   : rd_data_a;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(2), .TURNAROUND(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_data(cmd_data), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .busy(busy_a),
    .ss_n(ss_n_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_master #(.CLK_DIV(1), .TURNAROUND(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_data(cmd_data), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b),
    .ss_n(ss_n_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
  );

  // Mode-0 slave: read bit n is the one sampled on rise 10+TA+n; junk elsewhere.
  int   rises_s [2];
  logic psclk_s [2];

  function automatic logic slave_bit(input int r, input int ta);
    int b;
    logic [7:0] v;
    b = r - 10 - ta;
    v = slave_byte;
    if (b >= 0 && b < 8) return v[7-b];
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (ss_n_a) rises_s[0] = 0;
    else if (sclk_a && !psclk_s[0]) rises_s[0] = rises_s[0] + 1;
    psclk_s[0] = sclk_a;
    if (!sclk_a) miso_a = slave_bit(rises_s[0], 2);
    if (ss_n_b) rises_s[1] = 0;
    else if (sclk_b && !psclk_s[1]) rises_s[1] = rises_s[1] + 1;
    psclk_s[1] = sclk_b;
    if (!sclk_b) miso_b = slave_bit(rises_s[1], 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Observes one frame starting at the negedge after the accept edge.
  // mode 0: drop valid; 1: keep valid, swap data to nxt; 2: drop, then pulse nxt mid-frame.
  task automatic watch(input logic [9:0] cmd, input logic [7:0] rbyte, input int mode,
                       input logic [9:0] nxt, input string tag, output int gap);
    int cd, ta, exp_low, exp_rises, k, low, first_hi, first_rise, rises;
    int rdv_cnt, rdv_k, ready_k, run;
    bit rd, busy_ok, phase_ok, rest_zero, ss_cont;
    logic psclk;
    logic [9:0] obs;
    logic [7:0] exp_rd;
    cd = sel ? 1 : 2;
    ta = sel ? 0 : 2;
    rd = (cmd[9:8] == 2'b11);
    exp_low   = rd ? (18 + ta) * 2 * cd : 20 * cd;
    exp_rises = rd ? 18 + ta : 10;
    exp_rd    = rd ? rbyte : model_rd[sel];
    k = 0; low = 0; first_hi = 0; first_rise = 0; rises = 0;
    rdv_cnt = 0; rdv_k = 0; ready_k = 0; run = 0;
    busy_ok = 1; phase_ok = 1; rest_zero = 1; ss_cont = 1;
    psclk = 1'b0; obs = '0;
    while (ready_k == 0 && k < exp_low + cd + 60) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (mode == 1) cmd_data = nxt;
        else cmd_valid = 1'b0;
      end
      if (mode == 2 && k == 5) begin
        chk({tag, "_ready_busy"}, m_ready, 0);
        cmd_valid = 1'b1;
        cmd_data  = nxt;
      end
      if (mode == 2 && k == 6) cmd_valid = 1'b0;
      if (m_busy !== !m_ready) busy_ok = 0;
      if (m_rdv) begin rdv_cnt++; rdv_k = k; end
      if (first_hi == 0 && m_ss_n === 1'b0) begin
        low++;
        if (k == 1) begin
          psclk = m_sclk;
          run   = 1;
          if (m_sclk !== 1'b0) phase_ok = 0;
        end else if (m_sclk === psclk) begin
          run++;
        end else begin
          if (run != cd) phase_ok = 0;
          if (m_sclk === 1'b1) begin
            if (rises < 10) obs[9-rises] = m_mosi;
            else if (m_mosi !== 1'b0) rest_zero = 0;
            if (rises == 0) first_rise = k;
            rises++;
          end
          run   = 1;
          psclk = m_sclk;
        end
      end else if (first_hi == 0) begin
        first_hi = k;
        if (run != cd) phase_ok = 0;
      end else if (m_ss_n !== 1'b1) begin
        ss_cont = 0;
      end
      if (m_ready === 1'b1) ready_k = k;
    end
    gap = ready_k - first_hi + 1;
    chk({tag, "_ss_low"},     low,        exp_low);
    chk({tag, "_ss_rise_at"}, first_hi,   exp_low + 1);
    chk({tag, "_ready_at"},   ready_k,    exp_low + cd + 1);
    chk({tag, "_rise1_at"},   first_rise, cd + 1);
    chk({tag, "_rises"},      rises,      exp_rises);
    chk({tag, "_mosi"},       obs,        cmd);
    chk({tag, "_mosi_tail"},  rest_zero,  1);
    chk({tag, "_phase"},      phase_ok,   1);
    chk({tag, "_busy"},       busy_ok,    1);
    chk({tag, "_ss_steady"},  ss_cont,    1);
    chk({tag, "_rdv_cnt"},    rdv_cnt,    rd ? 1 : 0);
    chk({tag, "_rdv_at"},     rdv_k,      rd ? exp_low + 1 : 0);
    chk({tag, "_rd_data"},    m_rd_data,  exp_rd);
    model_rd[sel] = exp_rd;
  endtask

  task automatic send(input logic [9:0] cmd, input logic [7:0] rbyte, input int mode,
                      input logic [9:0] nxt, input string tag, output int gap);
    @(negedge clk);
    chk({tag, "_ready_pre"}, m_ready, 1);
    slave_byte = rbyte;
    cmd_valid  = 1'b1;
    cmd_data   = cmd;
    @(posedge clk);
    watch(cmd, rbyte, mode, nxt, tag, gap);
  endtask

  initial begin
    int gap, n, r, quiet;
    logic p;
    logic [9:0] w1, w2, c;
    logic [7:0] rb;
    model_rd[0] = '0;
    model_rd[1] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss_n",  ss_n_a,    1);
    chk("rst_sclk",  sclk_a,    0);
    chk("rst_mosi",  mosi_a,    0);
    chk("rst_rdv",   rd_valid_a, 0);
    chk("rst_rd",    rd_data_a, 0);
    chk("rst_busy",  busy_a,    0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready_a, 1);

    send(10'b00_0101_1010, 8'h00, 0, '0, "wr_addr", gap);
    send(10'b11_0000_0000, 8'hC3, 0, '0, "rd_c3", gap);

    w1 = {1'b0, 1'($urandom_range(0, 1)), 8'($urandom)};
    w2 = {2'b10, ~w1[7:0]};
    send(w1, 8'h00, 1, w2, "b2b1", gap);
    chk("b2b_gap", gap, 3);
    @(posedge clk);
    watch(w2, 8'h00, 0, '0, "b2b2", gap);

    send({2'b01, 8'($urandom)}, 8'h00, 2, {2'b11, 8'($urandom)}, "blk", gap);
    quiet = 1;
    repeat (12) begin
      @(negedge clk);
      if (ss_n_a !== 1'b1 || cmd_ready_a !== 1'b1) quiet = 0;
    end
    chk("blk_no_extra", quiet, 1);

    for (int i = 0; i < 5; i++) begin
      c  = {2'($urandom_range(0, 3)), 8'($urandom)};
      rb = 8'($urandom);
      send(c, rb, 0, '0, $sformatf("rnd%0d", i), gap);
    end

    // Abort a read after four data bits have been captured.
    @(negedge clk);
    chk("rstm_ready_pre", cmd_ready_a, 1);
    slave_byte = 8'h5A;
    cmd_valid  = 1'b1;
    cmd_data   = 10'b11_1111_0000;
    @(posedge clk);
    n = 0; r = 0; p = 1'b0;
    while (r < 16 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) cmd_valid = 1'b0;
      if (sclk_a && !p) r++;
      p = sclk_a;
    end
    chk("rstm_reach", r, 16);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstm_ss_n", ss_n_a,    1);
    chk("rstm_sclk", sclk_a,    0);
    chk("rstm_mosi", mosi_a,    0);
    chk("rstm_busy", busy_a,    0);
    chk("rstm_rd",   rd_data_a, 0);
    chk("rstm_rdv",  rd_valid_a, 0);
    rst_n = 1'b1;
    model_rd[0] = '0;
    model_rd[1] = '0;
    send(10'b11_0000_0001, 8'($urandom), 0, '0, "rd_after_rst", gap);

    sel = 1'b1;
    send(10'b11_1010_0101, 8'hFF, 0, '0, "b_rd_ff", gap);
    send({2'b00, 8'($urandom)}, 8'h00, 0, '0, "b_wr", gap);
    send({2'b11, 8'($urandom)}, 8'($urandom), 0, '0, "b_rd_rnd", gap);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

- Serial initiator for the team's SPI slave/RAM subsystem. It accepts a 10-bit command word (2-bit opcode + 8-bit payload) over a valid/ready handshake.
- It shifts the command out on MOSI in a single SS_n frame, using SPI mode 0.
- For read-data commands (opcode 2'b11) it continues clocking after a turnaround and captures one 8-bit byte from MISO.
- It is the host-side counterpart of the RAM-backed slave.

## Interface
Parameters:
- CLK_DIV, 2 — SCLK half-period in clk cycles; legal range ≥1.
- TURNAROUND, 2 — number of SCLK cycles between the last command bit and the first read bit; MISO is ignored during them; legal range ≥0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-low.
- cmd_valid  in  1  command word offered.
- cmd_ready  out  1  high when the master is in IDLE; a transfer happens when cmd_valid && cmd_ready.
- cmd_data  in  10  [9:8] opcode, [7:0] payload.
- rd_data  out  8  last byte read; held until the next read completes.
- rd_valid  out  1  one-clk pulse when rd_data updates.
- busy  out  1  high from acceptance until return to IDLE.
- ss_n  out  1  slave select, active-low.
- sclk  out  1  serial clock, idles low.
- mosi  out  1  serial data out, MSB first.
- miso  in  1  serial data in, MSB first.

## Operation
- Reset values: ss_n=1, sclk=0, mosi=0, rd_valid=0, rd_data=0, busy=0, state=IDLE.
- cmd_ready is combinational (state==IDLE), so it is 1 on the first clk after reset is released.
- FSM states: IDLE, CMD, TURN, READ, DONE.
- IDLE: on cmd_valid&&cmd_ready, latch cmd_data into the shift register and go to CMD.
  - On the next clk: ss_n=0, sclk=0, mosi=cmd_data[9].
- Every SCLK bit period is CLK_DIV clks low, then CLK_DIV clks high.
- CMD:
  - Slave samples on the rising edge; mosi changes only on the sclk falling edge (or at frame start).
  - After the 10th high phase:
    - opcode 2'b11 → TURN.
    - any other opcode → DONE.
- TURN: TURNAROUND full SCLK periods; mosi=0; MISO ignored; then READ. With TURNAROUND=0, go directly to READ.
- READ:
  - 8 SCLK periods; mosi=0.
  - MISO is shifted into an 8-bit register on the clk edge that raises sclk (MSB first).
- DONE:
  - Entry: sclk=0, ss_n=1, mosi=0.
  - If the frame was a read: rd_data ← shift register and rd_valid=1 in the entry cycle.
  - Hold for CLK_DIV clks, then go to IDLE.
- cmd_valid is ignored while busy.
- cmd_data is sampled only at acceptance; later changes have no effect.
- Reset asserted mid-frame: all outputs return to their reset values on the next clk edge and the frame is abandoned. rd_data keeps no partial byte.

## Timing
- Let T0 be the accept edge.
- ss_n low from T0+1.
- Write-class frame (opcodes 00/01/10):
  - ss_n low for 20·CLK_DIV clks.
  - ss_n high at T0+1+20·CLK_DIV.
  - cmd_ready high at T0+1+21·CLK_DIV.
- Read frame:
  - ss_n low for (18+TURNAROUND)·2·CLK_DIV clks.
  - rd_valid coincides with the ss_n rising edge.
- Minimum ss_n high time between back-to-back frames: CLK_DIV+1 clks.
- First sclk rising edge at T0+1+CLK_DIV; successive rising edges every 2·CLK_DIV clks.

## Structure
- Package spi_pkg holds:
  - opcode constants: OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - CMD_W=10 and DATA_W=8;
  - the state enumeration (IDLE, CMD, TURN, READ, DONE).
- Sub-module spi_clk_div:
  - half-period counter that produces sclk plus one-clk rise/fall strobes;
  - enabled only while in CMD, TURN or READ;
  - cleared on state entry.
- Top level: FSM, bit counter (0–9 for CMD, 0–7 for READ, 0–TURNAROUND-1 for TURN), TX/RX shift registers.

## Test plan
- Write-address frame: CLK_DIV=2, send 10'b00_0101_1010.
  - mosi sequence at rising edges is 0,0,0,1,0,1,1,0,1,0.
  - ss_n low exactly 40 clks; rd_valid never asserts; cmd_ready returns at T0+43.
- Read-data frame: slave model drives 0xC3, CLK_DIV=2, TURNAROUND=2, send 10'b11_0000_0000.
  - ss_n low 80 clks; exactly 8 sclk rises after the turnaround.
  - rd_data=0xC3 with a single rd_valid pulse in the ss_n-rise cycle.
- Back-to-back: cmd_valid held high with two write commands.
  - ss_n high for exactly 3 clks between frames.
  - The second frame's mosi reflects the second word.
- Busy blocking: pulse cmd_valid with new data mid-frame.
  - Ignored: cmd_ready=0, the current frame is unchanged, no extra frame follows.
- Reset mid-READ: assert rst_n=0 for 1 clk after 4 read bits.
  - Next clk: ss_n=1, sclk=0, mosi=0, busy=0, rd_data=0, no rd_valid.
  - A subsequent read returns the correct byte.
- Boundary: CLK_DIV=1, TURNAROUND=0, read frame with the slave driving 0xFF.
  - sclk toggles every clk; ss_n low 36 clks; rd_data=0xFF.
